id_alu_decode: RTL and testbench

Registered instruction-decode stage for the RV32I core. It consumes a fetched 32-bit instruction and produces the 4-bit ALU CONTROL code, operand selects, register indices, the sign-extended immediate and memory/branch/writeback controls. The ALU and datapath downstream consume these outputs. The stage sits between fetch and execute behind a one-deep valid/ready pipeline register with stall and flush.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/alu_ctrl_dec.sv | 136 +++++++++++++
 rtl/id_alu_decode.sv | 91 +++++++++
 tb/tb_id_alu_decode.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and the decoded-control bundle.
package riscv_pkg;

  localparam int IMM_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_BNE   = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_BGE   = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;
  localparam logic [3:0] ALU_SLTIU = 4'b1101;
  localparam logic [3:0] ALU_SRA   = 4'b1110;
  localparam logic [3:0] ALU_BEQ   = 4'b1111;

  typedef struct packed {
    logic [3:0]       control;
    logic             alusrc;
    logic             asel_pc;
    logic [IMM_W-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             br_pol;
    logic [2:0]       funct3;
    logic             illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I instruction decoder: instruction word to ALU code, immediate and strobes.
// Zero latency, no state; illegal encodings keep their fields but have every side-effect strobe cleared.
module alu_ctrl_dec import riscv_pkg::*; (
  input  logic [31:0] instr,
  output dec_ctrl_t   dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    dec        = '0;
    dec.rs1    = instr[19:15];
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    case (opc)
      OPC_OP: begin
        dec.rs2       = instr[24:20];
        dec.reg_write = 1'b1;
        dec.illegal   = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
        case (f3)
          3'b000:         dec.control = f7_alt ? ALU_SUB : ALU_ADD;
          3'b001:         dec.control = ALU_SLL;
          3'b010, 3'b011: dec.control = ALU_SLT;
          3'b100:         dec.control = ALU_XOR;
          3'b101:         dec.control = f7_alt ? ALU_SRA : ALU_SRL;
          3'b110:         dec.control = ALU_OR;
          default:        dec.control = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        case (f3)
          3'b000: dec.control = ALU_ADD;
          3'b001: begin
            dec.control = ALU_SLL;
            dec.imm     = imm_sh;
            dec.illegal = !f7_zero;
          end
          3'b010: dec.control = ALU_SLT;
          3'b011: dec.control = ALU_SLTIU;
          3'b100: dec.control = ALU_XOR;
          3'b101: begin
            dec.control = f7_alt ? ALU_SRA : ALU_SRL;
            dec.imm     = imm_sh;
            dec.illegal = !(f7_zero || f7_alt);
          end
          3'b110:  dec.control = ALU_OR;
          default: dec.control = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        dec.alusrc    = 1'b1;
        dec.imm       = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.alusrc    = 1'b1;
        dec.imm       = imm_s;
        dec.rs2       = instr[24:20];
        dec.rd        = 5'd0;
        dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.rs2    = instr[24:20];
        dec.rd     = 5'd0;
        dec.branch = 1'b1;
        // ZERO==1 means "taken" only for the equality compares; less-than results invert that sense
        case (f3)
          3'b000: begin dec.control = ALU_BEQ; dec.br_pol = 1'b1; end
          3'b001: begin dec.control = ALU_BNE; dec.br_pol = 1'b1; end
          3'b100, 3'b110: dec.control = ALU_SLT;
          3'b101, 3'b111: dec.control = ALU_BGE;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.control   = ALU_PASSB;
        dec.alusrc    = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.asel_pc   = 1'b1;
        dec.alusrc    = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.asel_pc   = 1'b1;
        dec.alusrc    = 1'b1;
        dec.imm       = imm_j;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.asel_pc   = 1'b1;
        dec.alusrc    = 1'b1;
        dec.imm       = imm_i;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = (f3 != 3'b000);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

endmodule

// File: rtl/id_alu_decode.sv
// Registered decode stage between fetch and execute: one-deep valid/ready register with stall and flush.
// Latency 1 cycle; stalls hold outputs bit-exact with IN_READY low; FLUSH drops held and incoming work.
module id_alu_decode import riscv_pkg::*; #(
  parameter int XLEN         = 32,
  parameter bit RESET_PC_NOP = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTR,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  input  logic            FLUSH,
  output logic [3:0]      CONTROL,
  output logic            ALUSRC,
  output logic            ASEL_PC,
  output logic [XLEN-1:0] IMM,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  output logic [4:0]      RD,
  output logic            REG_WRITE,
  output logic            MEM_READ,
  output logic            MEM_WRITE,
  output logic            BRANCH,
  output logic            JUMP,
  output logic            BR_POL,
  output logic [2:0]      FUNCT3,
  output logic            ILLEGAL
);

  dec_ctrl_t dec;
  dec_ctrl_t ctrl_d, ctrl_q;
  logic      valid_d, valid_q;
  logic      in_ready;

  alu_ctrl_dec u_dec (
    .instr (INSTR),
    .dec   (dec)
  );

  assign in_ready = !valid_q || OUT_READY;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (FLUSH) begin
      // Payload may stay, but nothing with a side effect may survive a flush
      valid_d          = 1'b0;
      ctrl_d.reg_write = 1'b0;
      ctrl_d.mem_read  = 1'b0;
      ctrl_d.mem_write = 1'b0;
      ctrl_d.branch    = 1'b0;
      ctrl_d.jump      = 1'b0;
    end else if (in_ready) begin
      valid_d = IN_VALID;
      if (IN_VALID) begin
        ctrl_d = dec;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= !RESET_PC_NOP;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = valid_q;
  assign CONTROL   = ctrl_q.control;
  assign ALUSRC    = ctrl_q.alusrc;
  assign ASEL_PC   = ctrl_q.asel_pc;
  assign IMM       = ctrl_q.imm;
  assign RS1       = ctrl_q.rs1;
  assign RS2       = ctrl_q.rs2;
  assign RD        = ctrl_q.rd;
  assign REG_WRITE = ctrl_q.reg_write;
  assign MEM_READ  = ctrl_q.mem_read;
  assign MEM_WRITE = ctrl_q.mem_write;
  assign BRANCH    = ctrl_q.branch;
  assign JUMP      = ctrl_q.jump;
  assign BR_POL    = ctrl_q.br_pol;
  assign FUNCT3    = ctrl_q.funct3;
  assign ILLEGAL   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_alu_decode.sv
// Self-checking bench for id_alu_decode: hand-decoded expectations queued on accept, popped on output.
module tb_id_alu_decode;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        IN_VALID;
  logic        IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        FLUSH;
  logic [3:0]  CONTROL;
  logic        ALUSRC;
  logic        ASEL_PC;
  logic [31:0] IMM;
  logic [4:0]  RS1, RS2, RD;
  logic        REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, JUMP, BR_POL;
  logic [2:0]  FUNCT3;
  logic        ILLEGAL;

  always #5 CLK = ~CLK;

  id_alu_decode #(.XLEN(32), .RESET_PC_NOP(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FLUSH(FLUSH), .CONTROL(CONTROL),
    .ALUSRC(ALUSRC), .ASEL_PC(ASEL_PC), .IMM(IMM), .RS1(RS1), .RS2(RS2), .RD(RD),
    .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .BRANCH(BRANCH),
    .JUMP(JUMP), .BR_POL(BR_POL), .FUNCT3(FUNCT3), .ILLEGAL(ILLEGAL)
  );

  typedef struct packed {
    logic [3:0]  control;
    logic        alusrc;
    logic        asel_pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        br_pol;
    logic [2:0]  funct3;
    logic        illegal;
  } exp_t;

  localparam int NV = 12;

  exp_t        exp_q[$];
  logic [31:0] v_instr[NV];
  exp_t        v_exp[NV];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic exp_t mk(input logic [3:0] c, input logic al, input logic as,
                              input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                              input logic br, input logic jp, input logic pol,
                              input logic [2:0] f3, input logic ill);
    exp_t e;
    e.control = c;    e.alusrc = al;    e.asel_pc = as;   e.imm = imm;
    e.rs1 = r1;       e.rs2 = r2;       e.rd = rd;
    e.reg_write = rw; e.mem_read = mr;  e.mem_write = mw;
    e.branch = br;    e.jump = jp;      e.br_pol = pol;
    e.funct3 = f3;    e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t observed();
    return mk(CONTROL, ALUSRC, ASEL_PC, IMM, RS1, RS2, RD, REG_WRITE, MEM_READ, MEM_WRITE,
              BRANCH, JUMP, BR_POL, FUNCT3, ILLEGAL);
  endfunction

  task automatic init_vectors();
    //                      ctrl  al  as  imm            rs1    rs2    rd     rw  mr  mw  br  jp  pol f3    ill
    v_instr[0]  = 32'h002081B3; v_exp[0]  = mk(4'h0, 0, 0, 32'h0,        5'd1,  5'd2, 5'd3, 1, 0, 0, 0, 0, 0, 3'd0, 0); // add x3,x1,x2
    v_instr[1]  = 32'hFFF00093; v_exp[1]  = mk(4'h0, 1, 0, 32'hFFFFFFFF, 5'd0,  5'd0, 5'd1, 1, 0, 0, 0, 0, 0, 3'd0, 0); // addi x1,x0,-1
    v_instr[2]  = 32'h40435293; v_exp[2]  = mk(4'hE, 1, 0, 32'h4,        5'd6,  5'd0, 5'd5, 1, 0, 0, 0, 0, 0, 3'd5, 0); // srai x5,x6,4
    v_instr[3]  = 32'hFE209CE3; v_exp[3]  = mk(4'h3, 0, 0, 32'hFFFFFFF8, 5'd1,  5'd2, 5'd0, 0, 0, 0, 1, 0, 1, 3'd1, 0); // bne x1,x2,-8
    v_instr[4]  = 32'h0020A423; v_exp[4]  = mk(4'h0, 1, 0, 32'h8,        5'd1,  5'd2, 5'd0, 0, 0, 1, 0, 0, 0, 3'd2, 0); // sw x2,8(x1)
    v_instr[5]  = 32'h407302B3; v_exp[5]  = mk(4'h7, 0, 0, 32'h0,        5'd6,  5'd7, 5'd5, 1, 0, 0, 0, 0, 0, 3'd0, 0); // sub x5,x6,x7
    v_instr[6]  = 32'h0020C463; v_exp[6]  = mk(4'h4, 0, 0, 32'h8,        5'd1,  5'd2, 5'd0, 0, 0, 0, 1, 0, 0, 3'd4, 0); // blt x1,x2,+8
    v_instr[7]  = 32'h123452B7; v_exp[7]  = mk(4'hC, 1, 0, 32'h12345000, 5'd8,  5'd0, 5'd5, 1, 0, 0, 0, 0, 0, 3'd5, 0); // lui x5,0x12345
    v_instr[8]  = 32'hFFC1A203; v_exp[8]  = mk(4'h0, 1, 0, 32'hFFFFFFFC, 5'd3,  5'd0, 5'd4, 1, 1, 0, 0, 0, 0, 3'd2, 0); // lw x4,-4(x3)
    v_instr[9]  = 32'h010000EF; v_exp[9]  = mk(4'h0, 1, 1, 32'h10,       5'd0,  5'd0, 5'd1, 1, 0, 0, 0, 1, 0, 3'd0, 0); // jal x1,+16
    v_instr[10] = 32'h00000000; v_exp[10] = mk(4'h0, 0, 0, 32'h0,        5'd0,  5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1); // all-zero word
    v_instr[11] = 32'h000110E7; v_exp[11] = mk(4'h0, 1, 1, 32'h0,        5'd2,  5'd0, 5'd1, 0, 0, 0, 0, 0, 0, 3'd1, 1); // jalr funct3=001
  endtask

  task automatic test_reset();
    RESET = 1'b1; INSTR = 32'h0; IN_VALID = 1'b0; OUT_READY = 1'b1; FLUSH = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (OUT_VALID !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID);
    end
    vectors++;
    if (observed() !== exp_t'(0)) begin
      miscompares++; $display("FAIL reset_payload: got %h expected 0", observed());
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    OUT_READY = 1'b1; FLUSH = 1'b0;
    for (int i = 0; i < NV; i++) begin
      INSTR = v_instr[i]; IN_VALID = 1'b1;
      #1;
      vectors++;
      if (IN_READY !== 1'b1) begin
        miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, IN_READY);
      end
      exp_q.push_back(v_exp[i]);
      @(posedge CLK); #1;
      vectors++;
      if (OUT_VALID !== 1'b1 || exp_q.size() == 0) begin
        miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, OUT_VALID);
      end else begin
        e = exp_q.pop_front();
        if (observed() !== e) begin
          miscompares++;
          $display("FAIL b2b_decode[%0d] instr %h: got %h expected %h", i, v_instr[i], observed(), e);
        end
      end
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b0) begin
      miscompares++; $display("FAIL idle_bubble: got %b expected 0", OUT_VALID);
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    exp_t e;
    OUT_READY = 1'b1; FLUSH = 1'b0;
    INSTR = v_instr[0]; IN_VALID = 1'b1;
    exp_q.push_back(v_exp[0]);
    @(posedge CLK); #1;
    e = exp_q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL stall_load: got v=%b %h expected v=1 %h", OUT_VALID, observed(), e);
    end
    OUT_READY = 1'b0; INSTR = v_instr[1]; IN_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (IN_READY !== 1'b0) begin
        miscompares++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, IN_READY);
      end
      @(posedge CLK); #1;
      vectors++;
      if (OUT_VALID !== 1'b1 || observed() !== v_exp[0]) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b %h expected v=1 %h", c, OUT_VALID, observed(), v_exp[0]);
      end
    end
    OUT_READY = 1'b1;
    #1;
    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++; $display("FAIL stall_release_ready: got %b expected 1", IN_READY);
    end
    exp_q.push_back(v_exp[1]);
    @(posedge CLK); #1;
    e = exp_q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL stall_release: got v=%b %h expected v=1 %h", OUT_VALID, observed(), e);
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_flush();
    exp_t e;
    OUT_READY = 1'b1; FLUSH = 1'b0;
    INSTR = v_instr[4]; IN_VALID = 1'b1;
    exp_q.push_back(v_exp[4]);
    @(posedge CLK); #1;
    e = exp_q.pop_front();
    vectors++;
    if (OUT_VALID !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL flush_load_sw: got v=%b %h expected v=1 %h", OUT_VALID, observed(), e);
    end
    FLUSH = 1'b1; OUT_READY = 1'b0; INSTR = v_instr[0]; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b0 || MEM_WRITE !== 1'b0 || REG_WRITE !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_kill: got v=%b mw=%b rw=%b expected 0 0 0", OUT_VALID, MEM_WRITE, REG_WRITE);
    end
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b0) begin
      miscompares++; $display("FAIL flush_drop_incoming: got %b expected 0", OUT_VALID);
    end
  endtask

  task automatic test_reset_in_stall();
    OUT_READY = 1'b1; FLUSH = 1'b0;
    INSTR = v_instr[5]; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0; IN_VALID = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b1 || CONTROL !== 4'b0111) begin
      miscompares++; $display("FAIL rst_stall_held: got v=%b ctrl=%b expected v=1 ctrl=0111", OUT_VALID, CONTROL);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b0 || CONTROL !== 4'b0000 || observed() !== exp_t'(0)) begin
      miscompares++;
      $display("FAIL rst_stall_clear: got v=%b %h expected v=0 0", OUT_VALID, observed());
    end
    RESET = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b0) begin
      miscompares++; $display("FAIL rst_stall_after: got %b expected 0", OUT_VALID);
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_in_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
